apb_uart_bridge: RTL and testbench
==================================

Name: apb_uart_bridge

Overview:
- APB3 slave register front-end for the FIFO-buffered UART core.
- Sits between the cluster APB interconnect and the UART/FIFO block: drives `tx_byte`/`transmit`/`rx_fifo_pop`, consumes `rx_byte`/`tx_fifo_full`/`rx_fifo_empty`/`busy`/`irq`.
- Converts bus accesses into single-cycle FIFO push/pop strobes; provides status, interrupt masking and a TX-drop counter.

Parameters:
- DATA_W, 16, APB data width (bits 7:0 carry UART data).
- ADDR_W, 4, APB address width; register select = paddr[3:2].
- DROP_W, 8, width of saturating TX-drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  ADDR_W  APB address
- pwdata  in  DATA_W  APB write data
- prdata  out  DATA_W  APB read data, valid when pready=1
- pready  out  1  APB ready
- pslverr  out  1  APB error
- irq_out  out  1  masked interrupt to cluster
- tx_byte  out  8  byte to UART TX FIFO
- transmit  out  1  one-cycle TX FIFO push strobe
- rx_fifo_pop  out  1  one-cycle RX FIFO pop strobe
- rx_byte  in  8  head of RX FIFO
- tx_fifo_full  in  1  TX FIFO full
- rx_fifo_empty  in  1  RX FIFO empty
- busy  in  1  UART receiving/transmitting
- irq_in  in  1  UART raw interrupt

Behaviour:
- Reset values: prdata=0, pready=0, pslverr=0, transmit=0, rx_fifo_pop=0, tx_byte=0, irq_out=0, CTRL=0, drop counter=0, irq_pend=0, FSM=IDLE.
- Register map, paddr[3:2]:
  - 0 DATA: write pushes pwdata[7:0]; read returns {0, rx_byte} and pops.
  - 1 STATUS (RO): bit0 rx_fifo_empty, bit1 tx_fifo_full, bit2 busy, bit3 irq_pend, bits[15:8] drop counter.
  - 2 CTRL (RW): bit0 irq_en, bit1 drop_clr (self-clearing, reads 0).
  - 3 IRQ: read returns irq_pend in bit0; write 1 to bit0 clears it.
- FSM states:
  - IDLE → SETUP when psel & !penable.
  - SETUP → ACCESS when psel & penable. Register select, data and side effects are latched here.
  - ACCESS: pready=1 for exactly one cycle, prdata/pslverr valid, then → IDLE.
  - Every transfer therefore has exactly one wait state.
  - psel dropped in SETUP → IDLE, no side effects.
- DATA write, tx_fifo_full=0 at SETUP→ACCESS: tx_byte=pwdata[7:0] and transmit=1 for exactly the ACCESS cycle.
- DATA write with tx_fifo_full=1: no strobe; drop counter += 1, saturating at 2^DROP_W-1.
- DATA read, rx_fifo_empty=0: rx_byte sampled at SETUP→ACCESS into prdata; rx_fifo_pop=1 for exactly the ACCESS cycle, which is after the sample, so no data skew.
- DATA read, rx_fifo_empty=1: prdata=0, no pop.
- Strobes never exceed one cycle. No strobe is issued on a STATUS/CTRL/IRQ access.
- irq_pend: set on a rising edge of irq_in (registered edge detect). IRQ write-1 clears it. If set and clear coincide, set wins.
- irq_out = irq_pend & irq_en, registered.
- drop_clr write zeroes the counter; it wins over a simultaneous increment.
- Reset mid-transfer: returns to IDLE next cycle, strobes deasserted, no partial push/pop.
- Unused prdata bits read 0. Writes to STATUS are ignored.

Optional Feature:
- Macro: `APB_UART_BRIDGE_PSLVERR_EN`.
- Defined:
  - pslverr=1 in ACCESS for a DATA write while TX full.
  - pslverr=1 in ACCESS for a DATA read while RX empty.
  - pslverr=1 in ACCESS for a write to STATUS.
  - Side-effect rules are unchanged; the drop counter still increments.
- Undefined: pslverr tied 0.

Test Plan:
- Reset held 3 cycles mid-ACCESS → all outputs 0, FSM IDLE, next transfer completes normally.
- Write DATA=0x00A5, tx_fifo_full=0 → transmit high exactly 1 cycle with tx_byte=0xA5; pready high 1 cycle, 2 cycles after SETUP.
- tx_fifo_full=1, 3 DATA writes → no transmit; STATUS[15:8]=0x03. Then CTRL write 0x0002 → STATUS[15:8]=0x00. 300 dropped writes → counter saturates at 0xFF.
- rx_byte=0x3C, rx_fifo_empty=0, DATA read → prdata=0x003C and rx_fifo_pop 1 cycle in ACCESS. With rx_fifo_empty=1 → prdata=0x0000, no pop.
- irq_in pulse with CTRL.irq_en=1 → irq_out=1 until IRQ write 0x0001. Same with irq_en=0 → irq_out stays 0, IRQ read=0x0001. Clear coinciding with a new irq_in edge → irq_pend stays 1.
- With PSLVERR_EN: DATA read while empty → pslverr=1. Write to STATUS → pslverr=1. Valid DATA write → pslverr=0.

Source files
------------

// File: rtl/apb_uart_bridge.sv
// APB3 slave register front-end for the FIFO-buffered UART core.
// Turns bus accesses into single-cycle FIFO push/pop strobes and exposes
// status, interrupt masking and a saturating TX-drop counter.
// Every transfer takes exactly one wait state (IDLE -> SETUP -> ACCESS).
// Optional feature: define APB_UART_BRIDGE_PSLVERR_EN to report pslverr on
// DATA writes while TX is full, DATA reads while RX is empty, and STATUS writes.
module apb_uart_bridge #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq_out,
  output logic [7:0]        tx_byte,
  output logic              transmit,
  output logic              rx_fifo_pop,
  input  logic [7:0]        rx_byte,
  input  logic              tx_fifo_full,
  input  logic              rx_fifo_empty,
  input  logic              busy,
  input  logic              irq_in
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_IRQ    = 2'd3;

  state_t              state, next_state;
  logic [1:0]          reg_sel;
  logic                do_access;
  logic                tx_push, rx_pop, drop_inc, drop_clr, ctrl_wr;
  logic                irq_clr, irq_rise, err_cond;
  logic                irq_en, irq_pend, irq_in_d;
  logic [DROP_W-1:0]   drop_cnt;
  logic [DATA_W-1:0]   rd_mux;
  logic                unused_bits;

  assign reg_sel     = paddr[3:2];
  assign unused_bits = ^{paddr[1:0], pwdata[DATA_W-1:8]};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: one SETUP cycle, one ACCESS cycle, abort if psel drops.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:    if (psel && !penable) next_state = SETUP;
      SETUP: begin
        if (!psel)                next_state = IDLE;
        else if (penable)         next_state = ACCESS;
      end
      ACCESS:                     next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  // Access decode: all side effects are taken on the SETUP -> ACCESS edge.
  always_comb begin
    do_access = (state == SETUP) && psel && penable;
    tx_push   = do_access &&  pwrite && (reg_sel == REG_DATA) && !tx_fifo_full;
    drop_inc  = do_access &&  pwrite && (reg_sel == REG_DATA) &&  tx_fifo_full;
    rx_pop    = do_access && !pwrite && (reg_sel == REG_DATA) && !rx_fifo_empty;
    ctrl_wr   = do_access &&  pwrite && (reg_sel == REG_CTRL);
    drop_clr  = ctrl_wr && pwdata[1];
    irq_clr   = do_access &&  pwrite && (reg_sel == REG_IRQ) && pwdata[0];
    irq_rise  = irq_in && !irq_in_d;
`ifdef APB_UART_BRIDGE_PSLVERR_EN
    err_cond  = do_access && (
                  ( pwrite && (reg_sel == REG_DATA) && tx_fifo_full)  ||
                  (!pwrite && (reg_sel == REG_DATA) && rx_fifo_empty) ||
                  ( pwrite && (reg_sel == REG_STATUS)));
`else
    err_cond  = 1'b0;
`endif
  end

  // Read mux; unused bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_DATA:   if (!rx_fifo_empty) rd_mux[7:0] = rx_byte;
      REG_STATUS: begin
        rd_mux[0]          = rx_fifo_empty;
        rd_mux[1]          = tx_fifo_full;
        rd_mux[2]          = busy;
        rd_mux[3]          = irq_pend;
        rd_mux[8 +: DROP_W] = drop_cnt;
      end
      REG_CTRL:   rd_mux[0] = irq_en;
      REG_IRQ:    rd_mux[0] = irq_pend;
      default:    rd_mux = '0;
    endcase
  end

  // Bus response and FIFO strobes, registered so they live only in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      pready      <= 1'b0;
      prdata      <= '0;
      pslverr     <= 1'b0;
      transmit    <= 1'b0;
      rx_fifo_pop <= 1'b0;
      tx_byte     <= '0;
    end else begin
      pready      <= do_access;
      prdata      <= (do_access && !pwrite) ? rd_mux : '0;
      pslverr     <= err_cond;
      transmit    <= tx_push;
      rx_fifo_pop <= rx_pop;
      if (tx_push) tx_byte <= pwdata[7:0];
    end
  end

  // Control, drop counter and interrupt pending/masking.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= 1'b0;
      drop_cnt <= '0;
      irq_pend <= 1'b0;
      irq_in_d <= 1'b0;
      irq_out  <= 1'b0;
    end else begin
      irq_in_d <= irq_in;
      irq_out  <= irq_pend && irq_en;
      if (ctrl_wr) irq_en <= pwdata[0];
      // Clear beats a simultaneous increment; counter saturates at all-ones.
      if (drop_clr)                         drop_cnt <= '0;
      else if (drop_inc && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
      // A new edge beats a simultaneous write-1-to-clear.
      if (irq_rise)     irq_pend <= 1'b1;
      else if (irq_clr) irq_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Self-checking bench for apb_uart_bridge: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a register-level model.
module tb_apb_uart_bridge;

  logic        clk, rst;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [15:0] pwdata, prdata;
  logic        pready, pslverr, irq_out;
  logic [7:0]  tx_byte, rx_byte;
  logic        transmit, rx_fifo_pop, tx_fifo_full, rx_fifo_empty, busy, irq_in;

`ifdef APB_UART_BRIDGE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  apb_uart_bridge #(.DATA_W(16), .ADDR_W(4), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq_out(irq_out), .tx_byte(tx_byte),
    .transmit(transmit), .rx_fifo_pop(rx_fifo_pop), .rx_byte(rx_byte),
    .tx_fifo_full(tx_fifo_full), .rx_fifo_empty(rx_fifo_empty), .busy(busy),
    .irq_in(irq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Observations from the most recent transfer.
  logic [15:0] r_data;
  logic        r_err, r_rdy_after;
  logic [7:0]  r_txb;
  int          r_tx, r_pop, r_wait;

  // One APB transfer; inputs change and outputs are sampled on negedges.
  task automatic apb_xfer(input bit wr, input logic [1:0] sel, input logic [15:0] wd,
                          input bit raise_irq);
    bit got;
    got = 1'b0;
    r_tx = 0; r_pop = 0; r_wait = 0; r_data = '0; r_err = 1'b0; r_txb = '0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {sel, 2'b00}; pwdata = wd;
    @(negedge clk);
    r_tx += int'(transmit); r_pop += int'(rx_fifo_pop);
    penable = 1'b1;
    if (raise_irq) irq_in = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      r_wait++;
      r_tx += int'(transmit); r_pop += int'(rx_fifo_pop);
      if (pready) begin
        got = 1'b1; r_data = prdata; r_err = pslverr; r_txb = tx_byte;
      end
    end
    if (!got) check("pready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    r_tx += int'(transmit); r_pop += int'(rx_fifo_pop);
    r_rdy_after = pready;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic expect_xfer(input string tag, input logic [15:0] exp_data, input bit exp_err,
                             input int exp_tx, input logic [7:0] exp_txb, input int exp_pop);
    check($sformatf("%s_wait", tag), r_wait, 1);
    check($sformatf("%s_prdata", tag), r_data, exp_data);
    check($sformatf("%s_pslverr", tag), r_err, exp_err);
    check($sformatf("%s_transmit", tag), r_tx, exp_tx);
    check($sformatf("%s_pop", tag), r_pop, exp_pop);
    check($sformatf("%s_pready_1cyc", tag), r_rdy_after, 0);
    if (exp_tx != 0) check($sformatf("%s_txbyte", tag), r_txb, exp_txb);
  endtask

  function automatic logic [31:0] all_outs();
    return {8'h0, prdata[7:0] | prdata[15:8], tx_byte, 3'b0, pready, pslverr,
            transmit, rx_fifo_pop, irq_out};
  endfunction

  typedef struct {
    bit          wr;
    logic [1:0]  sel;
    logic [15:0] wd;
    bit          full, empty, bsy;
    logic [7:0]  rxb;
    logic [15:0] exp_data;
    bit          err_cond;
    int          exp_tx;
    logic [7:0]  exp_txb;
    int          exp_pop;
  } vec_t;

  vec_t vecs[$];

  // Register-level model state for the random phase.
  logic [7:0]  m_drop;
  bit          m_en, m_pend;

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    rx_byte = '0; tx_fifo_full = 0; rx_fifo_empty = 1; busy = 0; irq_in = 0;

    // Reset state.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", all_outs(), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", all_outs(), 32'd0);

    // Directed vector table, applied in order from reset state.
    vecs.push_back('{1, 2'd0, 16'h00A5, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 8'hA5, 0});
    vecs.push_back('{0, 2'd0, 16'h0000, 0, 0, 0, 8'h3C, 16'h003C, 0, 0, 8'h00, 1});
    vecs.push_back('{0, 2'd0, 16'h0000, 0, 1, 0, 8'h77, 16'h0000, 1, 0, 8'h00, 0});
    vecs.push_back('{1, 2'd0, 16'h0011, 1, 1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0});
    vecs.push_back('{0, 2'd1, 16'h0000, 1, 1, 1, 8'h00, 16'h0107, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 2'd1, 16'hFFFF, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0});
    vecs.push_back('{1, 2'd2, 16'h0003, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0});
    vecs.push_back('{0, 2'd2, 16'h0000, 0, 0, 0, 8'h00, 16'h0001, 0, 0, 8'h00, 0});
    vecs.push_back('{0, 2'd1, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0});
    vecs.push_back('{0, 2'd3, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 2'd0, 16'h1234, 0, 0, 0, 8'h00, 16'h0000, 0, 1, 8'h34, 0});
    vecs.push_back('{0, 2'd1, 16'h0000, 1, 0, 0, 8'h00, 16'h0002, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 2'd2, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0});
    vecs.push_back('{0, 2'd2, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0});
    foreach (vecs[i]) begin
      tx_fifo_full = vecs[i].full; rx_fifo_empty = vecs[i].empty;
      busy = vecs[i].bsy; rx_byte = vecs[i].rxb;
      apb_xfer(vecs[i].wr, vecs[i].sel, vecs[i].wd, 1'b0);
      expect_xfer($sformatf("vec%0d", i), vecs[i].exp_data, ERR_EN & vecs[i].err_cond,
                  vecs[i].exp_tx, vecs[i].exp_txb, vecs[i].exp_pop);
    end

    // Aborted transfer: psel dropped in SETUP has no effect.
    tx_fifo_full = 0; rx_fifo_empty = 0; busy = 0;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 4'h0; pwdata = 16'h0055;
    @(negedge clk);
    psel = 0; pwrite = 0;
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        seen += int'(transmit) + int'(pready) + int'(rx_fifo_pop);
      end
      check("abort_no_activity", seen, 0);
    end
    apb_xfer(1, 2'd0, 16'h0066, 1'b0);
    expect_xfer("after_abort", 16'h0000, 1'b0, 1, 8'h66, 0);

    // Drop counter: increment, clear, saturate.
    tx_fifo_full = 1; rx_fifo_empty = 0; busy = 0;
    for (int i = 0; i < 3; i++) begin
      apb_xfer(1, 2'd0, 16'h00C0 + 16'(i), 1'b0);
      check($sformatf("drop_w%0d_no_tx", i), r_tx, 0);
    end
    apb_xfer(0, 2'd1, 16'h0, 1'b0);
    check("drop_cnt3", r_data, 16'h0302);
    apb_xfer(1, 2'd2, 16'h0002, 1'b0);
    apb_xfer(0, 2'd1, 16'h0, 1'b0);
    check("drop_cleared", r_data, 16'h0002);
    apb_xfer(0, 2'd2, 16'h0, 1'b0);
    check("drop_clr_self_clearing", r_data, 16'h0000);
    for (int i = 0; i < 300; i++) apb_xfer(1, 2'd0, 16'h00EE, 1'b0);
    apb_xfer(0, 2'd1, 16'h0, 1'b0);
    check("drop_saturated", r_data, 16'hFF02);
    apb_xfer(1, 2'd2, 16'h0002, 1'b0);

    // Interrupt with irq_en=1.
    tx_fifo_full = 0; rx_fifo_empty = 1;
    apb_xfer(1, 2'd2, 16'h0001, 1'b0);
    @(negedge clk); irq_in = 1;
    @(negedge clk); irq_in = 0;
    repeat (3) @(negedge clk);
    check("irq_out_set", irq_out, 1);
    repeat (5) @(negedge clk);
    check("irq_out_held", irq_out, 1);
    apb_xfer(0, 2'd1, 16'h0, 1'b0);
    check("status_irq_pend", r_data, 16'h0009);
    apb_xfer(1, 2'd3, 16'h0001, 1'b0);
    @(negedge clk);
    check("irq_out_cleared", irq_out, 0);

    // Interrupt masked.
    apb_xfer(1, 2'd2, 16'h0000, 1'b0);
    @(negedge clk); irq_in = 1;
    @(negedge clk); irq_in = 0;
    repeat (4) @(negedge clk);
    check("irq_out_masked", irq_out, 0);
    apb_xfer(0, 2'd3, 16'h0, 1'b0);
    check("irq_read_pend", r_data, 16'h0001);

    // Clear coinciding with a new rising edge: set wins.
    apb_xfer(1, 2'd3, 16'h0001, 1'b1);
    irq_in = 0;
    apb_xfer(0, 2'd3, 16'h0, 1'b0);
    check("irq_set_wins", r_data, 16'h0001);
    apb_xfer(1, 2'd3, 16'h0001, 1'b0);
    apb_xfer(0, 2'd3, 16'h0, 1'b0);
    check("irq_cleared_again", r_data, 16'h0000);

    // Randomized traffic against the register-level model.
    m_drop = 8'd0; m_en = 1'b0; m_pend = 1'b0;
    for (int n = 0; n < 200; n++) begin
      bit          wr;
      logic [1:0]  sel;
      logic [15:0] wd, exp_data;
      bit          exp_err;
      int          exp_tx, exp_pop;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        irq_in = ~irq_in;
        if (irq_in) m_pend = 1'b1;
        @(negedge clk);
      end
      tx_fifo_full  = 1'($urandom_range(0, 1));
      rx_fifo_empty = 1'($urandom_range(0, 1));
      busy          = 1'($urandom_range(0, 1));
      rx_byte       = 8'($urandom);
      wr  = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      wd  = 16'($urandom);
      exp_data = 16'h0; exp_err = 1'b0; exp_tx = 0; exp_pop = 0;
      case (sel)
        2'd0: if (wr) begin
          if (tx_fifo_full) begin
            exp_err = ERR_EN;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
          end else exp_tx = 1;
        end else begin
          if (rx_fifo_empty) exp_err = ERR_EN;
          else begin exp_data = {8'h00, rx_byte}; exp_pop = 1; end
        end
        2'd1: if (wr) exp_err = ERR_EN;
              else exp_data = {m_drop, 4'h0, m_pend, busy, tx_fifo_full, rx_fifo_empty};
        2'd2: if (wr) begin
          m_en = wd[0];
          if (wd[1]) m_drop = 8'd0;
        end else exp_data = {15'h0, m_en};
        default: if (wr) begin
          if (wd[0]) m_pend = 1'b0;
        end else exp_data = {15'h0, m_pend};
      endcase
      apb_xfer(wr, sel, wd, 1'b0);
      expect_xfer($sformatf("rnd%0d", n), exp_data, exp_err, exp_tx, wd[7:0], exp_pop);
      @(negedge clk);
      check($sformatf("rnd%0d_irq_out", n), irq_out, m_pend & m_en);
    end

    // Reset held 3 cycles in the middle of an ACCESS cycle.
    irq_in = 0; tx_fifo_full = 1; rx_fifo_empty = 0; rx_byte = 8'h99;
    apb_xfer(1, 2'd0, 16'h0001, 1'b0);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = 4'h0;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    check("mid_access_pready", pready, 1);
    rst = 1; psel = 0; penable = 0;
    repeat (3) begin
      @(negedge clk);
      check("mid_reset_outputs", all_outs(), 32'd0);
    end
    rst = 0;
    tx_fifo_full = 0; rx_fifo_empty = 1; busy = 0;
    apb_xfer(0, 2'd1, 16'h0, 1'b0);
    expect_xfer("post_reset_status", 16'h0001, 1'b0, 0, 8'h00, 0);
    apb_xfer(1, 2'd0, 16'h005A, 1'b0);
    expect_xfer("post_reset_write", 16'h0000, 1'b0, 1, 8'h5A, 0);
    apb_xfer(0, 2'd2, 16'h0, 1'b0);
    check("post_reset_ctrl", r_data, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
